out_tx: RTL

Output-side responder for the core's `out` instruction.
- The decode stage raises `data_out` for one cycle per `out` instruction.
- This block captures the low byte of the operand into a byte FIFO and serialises it on a UART line (8N1, LSB first).
- It back-pressures the core when the FIFO is full.
- It sits between the execute stage's register read path and the board's TX pin.

---
 rtl/out_tx_pkg.sv | 13 +
 rtl/out_tx_sync.sv | 50 +++++
 rtl/out_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/out_tx_pkg.sv
// Shared definitions for the core's UART I/O units: TX state encoding and default baud divisor.
package out_tx_pkg;

  localparam int unsigned CLK_PER_BIT_DEFAULT = 868;

  typedef logic [1:0] tx_state_t;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/out_tx_sync.sv
// Single-clock FIFO with occupancy count; head entry is readable combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q != FULL_COUNT);
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/out_tx.sv
// UART transmitter for the `out` instruction: byte FIFO feeding an 8N1 serialiser.
module out_tx
  import out_tx_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        out_valid,
  input  logic [7:0]                  out_data,
  output logic                        out_ready,
  output logic                        txd,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int unsigned BW = $clog2(CLK_PER_BIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic          txd_q, txd_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, baud_zero, fifo_nonempty;
  logic [7:0]    head;

  assign out_ready     = (fifo_count != FULL_COUNT);
  assign push          = out_valid && out_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign baud_zero     = (baud_q == '0);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(out_data),
    .rdata_o(head),
    .count_o(fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = BAUD_RELOAD;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_zero) begin
          baud_d  = BAUD_RELOAD;
          idx_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_zero) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = TX_STOP;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        // STOP chains straight into the next START when a byte is waiting.
        if (baud_zero) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = head;
            baud_d  = BAUD_RELOAD;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
    endcase

    // txd is registered from the next state so the line changes with the state.
    txd_d = 1'b1;
    if (state_d == TX_START)     txd_d = 1'b0;
    else if (state_d == TX_DATA) txd_d = shift_d[0];

    overflow_d = overflow_q || (out_valid && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      baud_q     <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  assign txd      = txd_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != TX_IDLE) || fifo_nonempty;

endmodule
